// File: rtl/proc_param_pkg.sv
// Shared opcode and FSM state definitions for the parameterised processor.
package proc_param_pkg;

    typedef enum logic [2:0] {
        OP_MV   = 3'b000,
        OP_MVI  = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_XOR  = 3'b110,
        OP_MVNZ = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_T1   = 2'd1,
        S_T2   = 2'd2,
        S_T3   = 2'd3
    } state_e;

endpackage

// File: rtl/proc_alu.sv
// Combinational ALU: arithmetic wraps modulo 2**N, zero flags an all-zero result.
module proc_alu
    import proc_param_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic [2:0]   op_i,
    output logic [N-1:0] result_o,
    output logic         zero_o
);

    // Operation select; non-ALU opcodes yield zero and are never committed.
    always_comb begin
        result_o = {N{1'b0}};
        case (opcode_e'(op_i))
            OP_ADD:  result_o = a_i + b_i;
            OP_SUB:  result_o = a_i - b_i;
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            default: result_o = {N{1'b0}};
        endcase
    end

    assign zero_o = (result_o == {N{1'b0}});

endmodule

// File: rtl/proc_param.sv
// Multi-cycle processor: register file, shared bus mux and IDLE/T1/T2/T3 sequencer.
module proc_param
    import proc_param_pkg::*;
#(
    parameter int N  = 16,
    parameter int RW = 3
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic [N-1:0] DIN,
    input  logic         Run,
    output logic         Done,
    output logic [N-1:0] BusOutput
);

    localparam int NR  = 2**RW;
    localparam int IRW = 3 + 2*RW;

    state_e         state_q, state_d;
    logic [IRW-1:0] ir_q;
    logic [N-1:0]   a_q, g_q;
    logic           z_q;
    logic [N-1:0]   regs_q [NR];

    opcode_e        op_s;
    logic [RW-1:0]  rx_s, ry_s;
    logic [N-1:0]   bus_s, alu_res_s;
    logic           alu_zero_s;
    logic           done_s, ir_load_s, a_load_s, g_load_s, reg_we_s;

    assign op_s = opcode_e'(ir_q[IRW-1:2*RW]);
    assign rx_s = ir_q[2*RW-1:RW];
    assign ry_s = ir_q[RW-1:0];

    proc_alu #(.N(N)) u_alu (
        .a_i      (a_q),
        .b_i      (bus_s),
        .op_i     (ir_q[IRW-1:2*RW]),
        .result_o (alu_res_s),
        .zero_o   (alu_zero_s)
    );

    // Sequencer: next state, bus source and write strobes from state and IR.
    always_comb begin
        state_d   = state_q;
        bus_s     = DIN;
        done_s    = 1'b0;
        ir_load_s = 1'b0;
        a_load_s  = 1'b0;
        g_load_s  = 1'b0;
        reg_we_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Run) begin
                    ir_load_s = 1'b1;
                    state_d   = S_T1;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_T1: begin
                case (op_s)
                    OP_MV: begin
                        bus_s    = regs_q[ry_s];
                        reg_we_s = 1'b1;
                        done_s   = 1'b1;
                        state_d  = S_IDLE;
                    end
                    OP_MVI: begin
                        bus_s    = DIN;
                        reg_we_s = 1'b1;
                        done_s   = 1'b1;
                        state_d  = S_IDLE;
                    end
                    OP_MVNZ: begin
                        bus_s    = regs_q[ry_s];
                        reg_we_s = ~z_q;
                        done_s   = 1'b1;
                        state_d  = S_IDLE;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        bus_s    = regs_q[rx_s];
                        a_load_s = 1'b1;
                        state_d  = S_T2;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
            S_T2: begin
                bus_s    = regs_q[ry_s];
                g_load_s = 1'b1;
                state_d  = S_T3;
            end
            S_T3: begin
                bus_s    = g_q;
                reg_we_s = 1'b1;
                done_s   = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, IR, A, G and Z registers.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            ir_q    <= {IRW{1'b0}};
            a_q     <= {N{1'b0}};
            g_q     <= {N{1'b0}};
            z_q     <= 1'b1;
        end else begin
            state_q <= state_d;
            if (ir_load_s) ir_q <= DIN[IRW-1:0];
            if (a_load_s)  a_q  <= bus_s;
            if (g_load_s) begin
                g_q <= alu_res_s;
                z_q <= alu_zero_s;
            end
        end
    end

    // General register file: single write port, always targets Rx from the bus.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < NR; i++) regs_q[i] <= {N{1'b0}};
        end else if (reg_we_s) begin
            regs_q[rx_s] <= bus_s;
        end
    end

    assign Done      = done_s;
    assign BusOutput = bus_s;

endmodule

// File: tb/tb_proc_param.sv
// Instruction-level model bench for proc_param at N=16/RW=3 and N=8/RW=2.
module tb_proc_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] din0 = 16'h0000;
    logic        run0 = 1'b0;
    logic        done0;
    logic [15:0] bus0;
    logic [7:0]  din1 = 8'h00;
    logic        run1 = 1'b0;
    logic        done1;
    logic [7:0]  bus1;

    always #5 clk = ~clk;

    proc_param #(.N(16), .RW(3)) dut16 (
        .Clock(clk), .Resetn(rst_n), .DIN(din0), .Run(run0),
        .Done(done0), .BusOutput(bus0)
    );

    proc_param #(.N(8), .RW(2)) dut8 (
        .Clock(clk), .Resetn(rst_n), .DIN(din1), .Run(run1),
        .Done(done1), .BusOutput(bus1)
    );

    typedef struct {
        int          inst;
        logic [15:0] bus;
        logic        done;
        string       tag;
    } exp_t;

    exp_t        expq[$];
    exp_t        ce;
    logic [15:0] mreg [2][8];
    logic        mz [2];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] act_bus;
    logic        act_done;

    function automatic int rw_of(input int inst);
        return (inst == 0) ? 3 : 2;
    endfunction

    function automatic logic [15:0] mask_of(input int inst);
        return (inst == 0) ? 16'hFFFF : 16'h00FF;
    endfunction

    // Instruction word with some ignored high bits set.
    function automatic logic [15:0] mkword(input int inst, input int opc, input int rx, input int ry);
        int rw;
        logic [15:0] w;
        rw = rw_of(inst);
        w = 16'((opc << (2*rw)) | (rx << rw) | ry);
        w = w | ((inst == 0) ? 16'h5000 : 16'h0080);
        return w;
    endfunction

    // Compare process: one expectation per cycle, checked at the falling edge.
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            ce = expq.pop_front();
            act_bus  = (ce.inst == 0) ? bus0 : {8'h00, bus1};
            act_done = (ce.inst == 0) ? done0 : done1;
            n_checks++;
            if (act_bus !== ce.bus) begin
                n_fail++;
                $display("FAIL %s bus: got %h expected %h at %0t", ce.tag, act_bus, ce.bus, $time);
            end
            n_checks++;
            if (act_done !== ce.done) begin
                n_fail++;
                $display("FAIL %s done: got %b expected %b at %0t", ce.tag, act_done, ce.done, $time);
            end
        end
    end

    task automatic step(input int inst, input logic r, input logic [15:0] d,
                        input logic [15:0] ebus, input logic edone, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        run0 = 1'b0;
        run1 = 1'b0;
        if (inst == 0) begin
            run0 = r;
            din0 = d;
        end else begin
            run1 = r;
            din1 = d[7:0];
        end
        e.inst = inst; e.bus = ebus; e.done = edone; e.tag = tag;
        expq.push_back(e);
    endtask

    task automatic idle(input int inst, input logic [15:0] d);
        step(inst, 1'b0, d, d & mask_of(inst), 1'b0, "idle");
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mz[i] = 1'b1;
            for (int j = 0; j < 8; j++) mreg[i][j] = 16'h0000;
        end
    endtask

    // Two reset cycles then one released idle cycle; asserted just after an edge.
    task automatic do_reset();
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            rst_n = 1'b0;
            run0 = 1'b0;
            run1 = 1'b0;
            din0 = 16'h1234 + 16'(k);
            e.inst = 0; e.bus = din0; e.done = 1'b0; e.tag = "reset";
            expq.push_back(e);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        din0 = 16'h00C3;
        e.inst = 0; e.bus = 16'h00C3; e.done = 1'b0; e.tag = "post_reset";
        expq.push_back(e);
    endtask

    task automatic exec(input int inst, input int opc, input int rx, input int ry,
                        input logic [15:0] imm, input logic hold);
        logic [15:0] m, w, a, b, g, junk;
        m = mask_of(inst);
        w = mkword(inst, opc, rx, ry);
        junk = 16'hA5C3;
        step(inst, 1'b1, w, w & m, 1'b0, "fetch");
        case (opc)
            0: begin
                step(inst, hold, junk, mreg[inst][ry], 1'b1, "mv_t1");
                mreg[inst][rx] = mreg[inst][ry];
            end
            1: begin
                step(inst, hold, imm & m, imm & m, 1'b1, "mvi_t1");
                mreg[inst][rx] = imm & m;
            end
            7: begin
                step(inst, hold, junk, mreg[inst][ry], 1'b1, "mvnz_t1");
                if (!mz[inst]) mreg[inst][rx] = mreg[inst][ry];
            end
            default: begin
                a = mreg[inst][rx];
                step(inst, hold, junk, a, 1'b0, "alu_t1");
                b = mreg[inst][ry];
                step(inst, hold, junk, b, 1'b0, "alu_t2");
                case (opc)
                    2: g = (a + b) & m;
                    3: g = (a - b) & m;
                    4: g = a & b;
                    5: g = a | b;
                    default: g = a ^ b;
                endcase
                mz[inst] = (g == 16'h0000);
                step(inst, hold, junk, g, 1'b1, "alu_t3");
                mreg[inst][rx] = g;
            end
        endcase
    endtask

    // Reads a register through MV r,r and expects a hand-computed literal.
    task automatic read_lit(input int inst, input int r, input logic [15:0] lit, input string tag);
        n_checks++;
        if (mreg[inst][r] !== lit) begin
            n_fail++;
            $display("FAIL %s model: got %h expected %h", tag, mreg[inst][r], lit);
        end
        step(inst, 1'b1, mkword(inst, 0, r, r), mkword(inst, 0, r, r) & mask_of(inst), 1'b0, "fetch");
        step(inst, 1'b0, 16'h0F0F, lit, 1'b1, tag);
    endtask

    initial begin
        model_reset();
        do_reset();
        idle(0, 16'h00AA);
        idle(0, 16'hFFFF);

        exec(0, 1, 0, 0, 16'h0005, 1'b0);
        read_lit(0, 0, 16'h0005, "mvi_r0");
        exec(0, 1, 1, 0, 16'h0007, 1'b0);
        exec(0, 2, 0, 1, 16'h0000, 1'b0);
        idle(0, 16'h7777);
        read_lit(0, 0, 16'h000C, "add_r0r1");
        exec(0, 7, 6, 0, 16'h0000, 1'b0);
        read_lit(0, 6, 16'h000C, "mvnz_z0");

        exec(0, 1, 2, 0, 16'h0003, 1'b0);
        exec(0, 1, 3, 0, 16'h0005, 1'b0);
        exec(0, 3, 2, 3, 16'h0000, 1'b0);
        read_lit(0, 2, 16'hFFFE, "sub_wrap");
        exec(0, 3, 4, 4, 16'h0000, 1'b0);
        read_lit(0, 4, 16'h0000, "sub_self");
        exec(0, 7, 5, 2, 16'h0000, 1'b0);
        exec(0, 1, 7, 0, 16'h1111, 1'b0);
        exec(0, 7, 5, 2, 16'h0000, 1'b0);
        read_lit(0, 5, 16'h0000, "mvnz_z1");

        exec(0, 1, 1, 0, 16'hF0F0, 1'b0);
        exec(0, 1, 3, 0, 16'h3C3C, 1'b0);
        exec(0, 4, 1, 3, 16'h0000, 1'b0);
        read_lit(0, 1, 16'h3030, "and");
        exec(0, 5, 1, 3, 16'h0000, 1'b0);
        exec(0, 6, 3, 1, 16'h0000, 1'b0);
        exec(0, 1, 6, 0, 16'h8001, 1'b0);
        exec(0, 2, 6, 6, 16'h0000, 1'b0);
        read_lit(0, 6, 16'h0002, "add_self");

        exec(0, 2, 0, 6, 16'h0000, 1'b1);
        exec(0, 0, 7, 0, 16'h0000, 1'b0);
        read_lit(0, 7, 16'h000E, "run_held");

        exec(0, 1, 1, 0, 16'h0009, 1'b0);
        step(0, 1'b1, mkword(0, 2, 1, 1), mkword(0, 2, 1, 1), 1'b0, "fetch");
        step(0, 1'b0, 16'hA5C3, 16'h0009, 1'b0, "abort_t1");
        do_reset();
        idle(0, 16'h4242);
        exec(0, 7, 2, 1, 16'h0000, 1'b0);
        read_lit(0, 1, 16'h0000, "abort_r1");
        read_lit(0, 2, 16'h0000, "abort_z1");

        idle(1, 16'h0033);
        exec(1, 1, 3, 0, 16'h00F0, 1'b0);
        exec(1, 1, 0, 0, 16'h00FF, 1'b0);
        exec(1, 6, 3, 0, 16'h0000, 1'b0);
        read_lit(1, 3, 16'h000F, "n8_xor");
        exec(1, 0, 1, 3, 16'h0000, 1'b0);
        read_lit(1, 1, 16'h000F, "n8_mv");
        exec(1, 2, 0, 0, 16'h0000, 1'b0);
        read_lit(1, 0, 16'h00FE, "n8_add_wrap");

        @(posedge clk);
        #1;
        run0 = 1'b0;
        run1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
